uart_mmio_fifo: RTL
===================

// Module: uart_mmio_fifo
// PURPOSE
//   Memory-mapped UART front end for the CPU's IO address space, with parametrised RX and TX FIFOs.
//   Sits between the datapath's memory stage and the existing UART module.
//   Software can burst up to TX_DEPTH bytes without polling and tolerate RX latency of RX_DEPTH bytes.
//   Adds sticky overflow status, FIFO fill levels and an interrupt line.
// PARAMETERS
//   BASE_ADDR  32'h80000000  base of the 8-word register window (word-aligned offsets 0x00-0x1C)
//   RX_DEPTH   8             RX FIFO entries; power of 2, 2..128
//   TX_DEPTH   8             TX FIFO entries; power of 2, 2..128
// PORTS
//   Clock      in   1   system clock; all state on posedge
//   Reset      in   1   synchronous, active-high
//   Addr       in   32  byte address from memory stage
//   WrData     in   32  store data; byte for TX taken from WrData[7:0]
//   IO_trans   in   4   store byte enables; any bit set = write cycle
//   IO_recv    in   1   load strobe
//   FPGA_Sin   in   1   serial in, to UART
//   FPGA_Sout  out  1   serial out, from UART
//   Received   out  32  load data, registered (valid the cycle after IO_recv)
//   Irq        out  1   level: (RX FIFO nonempty & rx_ie) | rx_overflow
// BEHAVIOUR
//   Register map, offsets from BASE_ADDR. Any unmapped offset reads 0; writes to it are ignored.
//     0x00 STATUS (RO):
//       [0] tx_ready = !tx_full; [1] rx_valid = !rx_empty; [2] rx_overflow (sticky);
//       [3] tx_empty; [15:8] rx_count; [23:16] tx_count; all other bits 0.
//     0x04 RXDATA (RO): read returns {24'b0, rx head} and pops one entry. Empty: reads 0, no pop.
//     0x08 TXDATA (WO): write pushes WrData[7:0]. Full: write dropped, no state change.
//     0x0C CTRL (RW): [0] rx_ie, reset 0.
//       Writing 1 to bit [1] clears rx_overflow; bit [1] always reads 0.
//   A cycle is a write when IO_trans != 0 and a load when IO_recv=1.
//   A write wins if both are asserted; no pop occurs in that cycle.
//   Received <= selected value on the posedge after the load cycle and holds until the next load.
//   RXDATA read latency is 1 cycle. The pop takes effect on the same edge that captures the head.
//   TX drain: UART DataInValid = !tx_empty and DataIn = TX head.
//     The FIFO pops on each cycle with DataInValid & DataInReady. Bytes leave in FIFO order.
//   RX fill: UART DataOutReady is tied to 1, so the UART is always drained.
//     On DataOutValid the byte is pushed if the FIFO is not full, or if a CPU pop happens in the same cycle.
//     Otherwise the byte is discarded and rx_overflow is set.
//   Simultaneous CPU push and UART pop on the TX FIFO: both happen and tx_count is unchanged.
//     The same applies to a UART push and CPU pop on the RX FIFO.
//   A push to a full FIFO with no pop in the same cycle: no pointer or count change.
//   FIFO pointers wrap modulo DEPTH. Counts are $clog2(DEPTH)+1 bits wide, zero-extended into STATUS.
//   Reset (at any time, including mid-frame) returns:
//     FIFOs empty; rx_overflow = 0; rx_ie = 0; Received = 0; Irq = 0; cycle counter = 0.
//     The UART is reset via the same Reset, so FPGA_Sout idles high.
// CONFIGURATION
//   IO_CYCLE_COUNTER_EN defined:
//     Offset 0x10 CYCLES (RW) is a 32-bit free-running counter, +1 per Clock, wrapping at 2^32.
//     Any write to 0x10 loads it to 0 on the next edge.
//   Not defined: offset 0x10 reads 0 and writes are ignored; no counter flops are synthesised.
// STRUCTURE
//   Shared package/header io_defs:
//     register offset constants (IO_STATUS=0x00, IO_RXDATA=0x04, IO_TXDATA=0x08, IO_CTRL=0x0C, IO_CYCLES=0x10);
//     STATUS and CTRL bit-index constants.
//   Sub-module io_fifo (params WIDTH=8, DEPTH):
//     sync FIFO with push, pop, head, full, empty and count outputs;
//     head is visible combinationally; instantiated twice.
//   The existing UART module is instantiated unmodified.
// TESTING
//   1. Reset, then load 0x00 -> Received = 32'h0000_0009 (tx_ready=1, tx_empty=1, rx_valid=0).
//   2. Write 0x41,0x42,0x43 to 0x08 back-to-back (TX_DEPTH=8):
//      STATUS[23:16] shows 3 the cycle after the last write (minus any already drained);
//      FPGA_Sout emits 0x41,0x42,0x43 in order.
//   3. Drive 9 bytes 0x00..0x08 into FPGA_Sin with no reads (RX_DEPTH=8):
//      STATUS = rx_count 8, rx_overflow 1, Irq 1;
//      8 reads of 0x04 return 0x00..0x07, a 9th read returns 0.
//   4. Write 0x2 to 0x0C -> rx_overflow = 0. Write 0x1 -> Irq follows rx_valid.
//      Fill TX with 8 bytes while UART is busy, then write 0xFF -> dropped;
//      readback stream has no 0xFF.
//   5. RX holds 1 byte while the UART delivers another; CPU reads 0x04 in the same cycle as DataOutValid:
//      rx_count stays 1 and no overflow.
//   6. With IO_CYCLE_COUNTER_EN: read 0x10 twice, N cycles apart -> delta = N.
//      Write 0x10 -> next read is small (< 4). Without the macro: read 0x10 -> 0.
//   Assert Reset mid-TX-frame -> FPGA_Sout = 1 and STATUS = 0x9 next cycle.

Source files
------------

// File: rtl/io_defs.sv
// Shared register offsets, STATUS/CTRL bit positions and UART state encodings
// for the memory-mapped UART front end.
package io_defs;

  localparam logic [4:0] IO_STATUS = 5'h00;
  localparam logic [4:0] IO_RXDATA = 5'h04;
  localparam logic [4:0] IO_TXDATA = 5'h08;
  localparam logic [4:0] IO_CTRL   = 5'h0C;
  localparam logic [4:0] IO_CYCLES = 5'h10;

  localparam int ST_TX_READY     = 0;
  localparam int ST_RX_VALID     = 1;
  localparam int ST_RX_OVERFLOW  = 2;
  localparam int ST_TX_EMPTY     = 3;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;

  localparam int CTRL_RX_IE   = 0;
  localparam int CTRL_CLR_OVF = 1;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with a combinational head. A push into a full FIFO is
// accepted only when a pop happens on the same edge.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge Clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart.sv
// 8N1 UART: one byte per DataInValid/DataInReady handshake on the transmit
// side, one DataOutValid pulse per received frame with a valid stop bit.
module uart
  import io_defs::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  input  logic       SIn,
  output logic       SOut
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  tx_state_t  tx_state, tx_next;
  logic [9:0] tx_shift;
  logic [3:0] tx_bits;
  logic [CW-1:0] tx_clk;
  logic       tx_tick;

  assign tx_tick     = (tx_clk == CW'(CLKS_PER_BIT - 1));
  assign DataInReady = (tx_state == TX_IDLE);
  assign SOut        = (tx_state == TX_SEND) ? tx_shift[0] : 1'b1;

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (DataInValid) tx_next = TX_SEND;
      TX_SEND: if (tx_tick && tx_bits == 4'd9) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  // Frame is {stop, data[7:0], start}, shifted out LSB first.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      tx_state <= TX_IDLE;
      tx_shift <= '1;
      tx_bits  <= '0;
      tx_clk   <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE) begin
        tx_clk  <= '0;
        tx_bits <= '0;
        if (DataInValid) tx_shift <= {1'b1, DataIn, 1'b0};
      end else if (tx_tick) begin
        tx_clk   <= '0;
        tx_bits  <= tx_bits + 4'd1;
        tx_shift <= {1'b1, tx_shift[9:1]};
      end else begin
        tx_clk <= tx_clk + CW'(1);
      end
    end
  end

  rx_state_t  rx_state, rx_next;
  logic [1:0] rx_sync;
  logic       sin_s;
  logic [7:0] rx_shift;
  logic [2:0] rx_bits;
  logic [CW-1:0] rx_clk;
  logic       rx_tick;
  logic       rx_half;

  assign sin_s   = rx_sync[1];
  assign rx_tick = (rx_clk == CW'(CLKS_PER_BIT - 1));
  assign rx_half = (rx_clk == CW'(CLKS_PER_BIT / 2 - 1));

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!sin_s) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = sin_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bits == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Sampling is aligned to the middle of each bit by the half-bit wait in RX_START.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rx_state     <= RX_IDLE;
      rx_sync      <= 2'b11;
      rx_shift     <= '0;
      rx_bits      <= '0;
      rx_clk       <= '0;
      DataOut      <= '0;
      DataOutValid <= 1'b0;
    end else begin
      rx_state <= rx_next;
      rx_sync  <= {rx_sync[0], SIn};
      if (DataOutValid && DataOutReady) DataOutValid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_clk  <= '0;
          rx_bits <= '0;
        end
        RX_START: rx_clk <= rx_half ? '0 : rx_clk + CW'(1);
        RX_DATA: begin
          if (rx_tick) begin
            rx_clk   <= '0;
            rx_bits  <= rx_bits + 3'd1;
            rx_shift <= {sin_s, rx_shift[7:1]};
          end else begin
            rx_clk <= rx_clk + CW'(1);
          end
        end
        default: begin
          if (rx_tick) begin
            rx_clk <= '0;
            if (sin_s) begin
              DataOut      <= rx_shift;
              DataOutValid <= 1'b1;
            end
          end else begin
            rx_clk <= rx_clk + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART front end with RX/TX FIFOs, sticky overflow and Irq.
// Define IO_CYCLE_COUNTER_EN to add the free-running CYCLES register at 0x10.
module uart_mmio_fifo
  import io_defs::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          RX_DEPTH     = 8,
  parameter int          TX_DEPTH     = 8,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  input  logic [3:0]  IO_trans,
  input  logic        IO_recv,
  input  logic        FPGA_Sin,
  output logic        FPGA_Sout,
  output logic [31:0] Received,
  output logic        Irq
);

  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  logic             in_window;
  logic [4:0]       offset;
  logic             is_write;
  logic             is_load;
  logic             wr_tx;
  logic             wr_ctrl;
  logic             rd_rx;
  logic [7:0]       tx_head;
  logic             tx_full;
  logic             tx_empty;
  logic             tx_valid;
  logic             tx_pop;
  logic [TX_CW-1:0] tx_count;
  logic [7:0]       rx_head;
  logic             rx_full;
  logic             rx_empty;
  logic [RX_CW-1:0] rx_count;
  logic             uart_in_ready;
  logic [7:0]       uart_out_data;
  logic             uart_out_valid;
  logic             rx_drop;
  logic             rx_overflow;
  logic             rx_ie;
  logic [31:0]      status;
  logic [31:0]      rd_value;
  logic             unused_bits;

  assign in_window = (Addr[31:5] == BASE_ADDR[31:5]);
  assign offset    = Addr[4:0];
  assign is_write  = |IO_trans;
  assign is_load   = IO_recv && !is_write;
  assign wr_tx     = is_write && in_window && (offset == IO_TXDATA);
  assign wr_ctrl   = is_write && in_window && (offset == IO_CTRL);
  assign rd_rx     = is_load && in_window && (offset == IO_RXDATA);
  assign tx_valid  = !tx_empty;
  assign tx_pop    = tx_valid && uart_in_ready;
  // A full RX FIFO is never empty, so any RXDATA load here is a real pop.
  assign rx_drop   = uart_out_valid && rx_full && !rd_rx;
  assign Irq       = (!rx_empty && rx_ie) || rx_overflow;
  assign unused_bits = ^WrData[31:8];

  io_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (wr_tx),
    .pop   (tx_pop),
    .din   (WrData[7:0]),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  io_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (uart_out_valid),
    .pop   (rd_rx),
    .din   (uart_out_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .Clock        (Clock),
    .Reset        (Reset),
    .DataIn       (tx_head),
    .DataInValid  (tx_valid),
    .DataInReady  (uart_in_ready),
    .DataOut      (uart_out_data),
    .DataOutValid (uart_out_valid),
    .DataOutReady (1'b1),
    .SIn          (FPGA_Sin),
    .SOut         (FPGA_Sout)
  );

  // A new overflow in the same cycle as a clear request leaves the flag set.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rx_overflow <= 1'b0;
      rx_ie       <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        rx_ie <= WrData[CTRL_RX_IE];
        if (WrData[CTRL_CLR_OVF]) rx_overflow <= 1'b0;
      end
      if (rx_drop) rx_overflow <= 1'b1;
    end
  end

`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0] cycles;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cycles <= '0;
    end else if (is_write && in_window && (offset == IO_CYCLES)) begin
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end
`endif

  always_comb begin
    status                          = '0;
    status[ST_TX_READY]             = !tx_full;
    status[ST_RX_VALID]             = !rx_empty;
    status[ST_RX_OVERFLOW]          = rx_overflow;
    status[ST_TX_EMPTY]             = tx_empty;
    status[ST_RX_COUNT_LSB +: 8]    = 8'(rx_count);
    status[ST_TX_COUNT_LSB +: 8]    = 8'(tx_count);
    rd_value = '0;
    if (in_window) begin
      case (offset)
        IO_STATUS: rd_value = status;
        IO_RXDATA: rd_value = rx_empty ? 32'h0 : {24'h0, rx_head};
        IO_CTRL:   rd_value[CTRL_RX_IE] = rx_ie;
`ifdef IO_CYCLE_COUNTER_EN
        IO_CYCLES: rd_value = cycles;
`endif
        default:   rd_value = '0;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Received <= '0;
    end else if (is_load) begin
      Received <= rd_value;
    end
  end

endmodule
